// File: rtl/sram_port_if.sv
// sram_port_if
//   One requester's req/gnt/rvalid bus into the SRAM port arbiter.
//   Signals:
//     req    requester -> arbiter  request, held until granted
//     gnt    arbiter -> requester  request accepted this cycle
//     we     requester -> arbiter  1 = write, 0 = read
//     be     requester -> arbiter  byte enables, be[k] covers data[8k+7:8k]
//     addr   requester -> arbiter  byte address
//     wdata  requester -> arbiter  write data
//     rvalid arbiter -> requester  response valid, one cycle after gnt
//     rdata  arbiter -> requester  read data, valid with rvalid on a read
//   Modports: master = requester side, slave = arbiter side.
interface sram_port_if;
    logic        req;
    logic        gnt;
    logic        we;
    logic [3:0]  be;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one 1024x32 SRAM macro between two requesters (port 0: CPU
//   peripheral bus, port 1: fabric user logic). Arbitrates every cycle,
//   drives the SRAM pins for the winner and routes the read data back one
//   cycle later to whichever port was granted.
//   Ports:
//     clk_i        clock, all state on the rising edge
//     rst_ni       asynchronous active-low reset
//     p0, p1       requester buses (sram_port_if, slave side)
//     sram_addr_o  SRAM word address
//     sram_bm_o    SRAM bit mask, expanded from the byte enables
//     sram_din_o   SRAM write data
//     sram_men_o   SRAM memory enable
//     sram_wen_o   SRAM write enable
//     sram_ren_o   SRAM read enable
//     sram_dout_i  SRAM read data, valid one cycle after a read access
//   Parameters:
//     ROUND_ROBIN  1: alternate between ports under contention; 0: port 0 wins
//     ADDR_LSB     byte address bit used as word address bit 0
module sram_port_arbiter #(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned ADDR_LSB    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    sram_port_if.slave  p0,
    sram_port_if.slave  p1,
    output logic [9:0]  sram_addr_o,
    output logic [31:0] sram_bm_o,
    output logic [31:0] sram_din_o,
    output logic        sram_men_o,
    output logic        sram_wen_o,
    output logic        sram_ren_o,
    input  logic [31:0] sram_dout_i
);

    logic        last_q;
    logic        resp_port_q;
    logic        resp_we_q;
    logic        rvalid_q;

    logic        win1;
    logic        grant;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [23:0] sel_addr;
    logic [31:0] sel_wdata;

    // Winner selection. When both ports request, round-robin hands the
    // access to the port that did not win last; otherwise port 0 has priority.
    always_comb begin
        win1 = 1'b0;
        if (p0.req && p1.req) begin
            win1 = ROUND_ROBIN ? (last_q == 1'b0) : 1'b0;
        end else begin
            win1 = p1.req;
        end
    end

    // Grants are suppressed while reset is held, so no access is issued.
    assign grant = rst_ni && (p0.req || p1.req);

    assign p0.gnt = grant && !win1;
    assign p1.gnt = grant && win1;

    assign sel_we    = win1 ? p1.we    : p0.we;
    assign sel_be    = win1 ? p1.be    : p0.be;
    assign sel_addr  = win1 ? p1.addr  : p0.addr;
    assign sel_wdata = win1 ? p1.wdata : p0.wdata;

    // SRAM pins: the access goes out in the grant cycle; idle pins are all zero.
    always_comb begin
        sram_addr_o = '0;
        sram_bm_o   = '0;
        sram_din_o  = '0;
        sram_men_o  = 1'b0;
        sram_wen_o  = 1'b0;
        sram_ren_o  = 1'b0;
        if (grant) begin
            sram_men_o  = 1'b1;
            sram_wen_o  = sel_we;
            sram_ren_o  = !sel_we;
            sram_addr_o = sel_addr[ADDR_LSB+9:ADDR_LSB];
            sram_din_o  = sel_wdata;
            for (int k = 0; k < 4; k++) begin
                sram_bm_o[8*k +: 8] = {8{sel_be[k]}};
            end
        end
    end

    // Response tracking: remember who was granted and whether it was a
    // write, so the following cycle can steer rvalid/rdata to that port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q      <= 1'b1;
            resp_port_q <= 1'b0;
            resp_we_q   <= 1'b0;
            rvalid_q    <= 1'b0;
        end else if (grant) begin
            last_q      <= win1;
            resp_port_q <= win1;
            resp_we_q   <= sel_we;
            rvalid_q    <= 1'b1;
        end else begin
            rvalid_q    <= 1'b0;
        end
    end

    // Write responses carry zero data; only a read passes SRAM DOUT through.
    assign p0.rvalid = rvalid_q && !resp_port_q;
    assign p1.rvalid = rvalid_q && resp_port_q;
    assign p0.rdata  = (p0.rvalid && !resp_we_q) ? sram_dout_i : '0;
    assign p1.rdata  = (p1.rvalid && !resp_we_q) ? sram_dout_i : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Directed bench for sram_port_arbiter. A round-robin instance is attached
//   to a behavioural 1024x32 SRAM; a fixed-priority instance is used for the
//   priority contention case. Inputs change on the falling edge and outputs
//   are compared 1 time unit later.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    sram_port_if p0 ();
    sram_port_if p1 ();
    sram_port_if f0 ();
    sram_port_if f1 ();

    logic [9:0]  sram_addr;
    logic [31:0] sram_bm;
    logic [31:0] sram_din;
    logic        sram_men;
    logic        sram_wen;
    logic        sram_ren;
    logic [31:0] sram_dout = '0;

    logic [9:0]  fx_addr;
    logic [31:0] fx_bm;
    logic [31:0] fx_din;
    logic        fx_men;
    logic        fx_wen;
    logic        fx_ren;
    logic [31:0] fx_dout = '0;

    sram_port_arbiter #(.ROUND_ROBIN(1'b1), .ADDR_LSB(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .p0          (p0),
        .p1          (p1),
        .sram_addr_o (sram_addr),
        .sram_bm_o   (sram_bm),
        .sram_din_o  (sram_din),
        .sram_men_o  (sram_men),
        .sram_wen_o  (sram_wen),
        .sram_ren_o  (sram_ren),
        .sram_dout_i (sram_dout)
    );

    sram_port_arbiter #(.ROUND_ROBIN(1'b0), .ADDR_LSB(2)) dut_fixed (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .p0          (f0),
        .p1          (f1),
        .sram_addr_o (fx_addr),
        .sram_bm_o   (fx_bm),
        .sram_din_o  (fx_din),
        .sram_men_o  (fx_men),
        .sram_wen_o  (fx_wen),
        .sram_ren_o  (fx_ren),
        .sram_dout_i (fx_dout)
    );

    // Behavioural SRAM: masked write in the access cycle, read data one cycle later.
    logic [31:0] mem [1024] = '{default: 32'h0};

    always @(posedge clk) begin
        if (sram_men) begin
            if (sram_wen) begin
                mem[sram_addr] <= (mem[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
            end else if (sram_ren) begin
                sram_dout <= mem[sram_addr];
            end
        end
    end

    // Drives both round-robin ports and reset on the falling edge, then
    // waits 1 time unit so outputs are settled for comparison.
    task automatic applyStimulus(
        input logic        rn,
        input logic        r0, input logic w0, input logic [3:0] b0,
        input logic [23:0] a0, input logic [31:0] d0,
        input logic        r1, input logic w1, input logic [3:0] b1,
        input logic [23:0] a1, input logic [31:0] d1
    );
        @(negedge clk);
        rst_n    = rn;
        p0.req   = r0; p0.we = w0; p0.be = b0; p0.addr = a0; p0.wdata = d0;
        p1.req   = r1; p1.we = w1; p1.be = b1; p1.addr = a1; p1.wdata = d1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        f0.req = 1'b0; f0.we = 1'b0; f0.be = 4'h0; f0.addr = '0; f0.wdata = '0;
        f1.req = 1'b0; f1.we = 1'b0; f1.be = 4'h0; f1.addr = '0; f1.wdata = '0;

        // Reset held with both ports requesting reads.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 24'h000010, 32'h0,
                            1'b1, 1'b0, 4'hF, 24'h000020, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 24'h000010, 32'h0,
                            1'b1, 1'b0, 4'hF, 24'h000020, 32'h0);
        checkOutput("rst_gnt0", p0.gnt, 0);
        checkOutput("rst_gnt1", p1.gnt, 0);
        checkOutput("rst_men", sram_men, 0);
        checkOutput("rst_rvalid0", p0.rvalid, 0);
        checkOutput("rst_rvalid1", p1.rvalid, 0);
        checkOutput("rst_rdata0", p0.rdata, 0);

        // Release: port 0 is favoured first.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 24'h000010, 32'h0,
                            1'b1, 1'b0, 4'hF, 24'h000020, 32'h0);
        checkOutput("first_gnt0", p0.gnt, 1);
        checkOutput("first_gnt1", p1.gnt, 0);
        checkOutput("first_ren", sram_ren, 1);
        checkOutput("first_addr", sram_addr, 4);

        // Port 0 writes DEADBEEF to byte address 0x10.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 24'h000010, 32'hDEADBEEF,
                            1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
        checkOutput("first_rvalid0", p0.rvalid, 1);
        checkOutput("first_rdata0", p0.rdata, 32'h0);
        checkOutput("wr_gnt0", p0.gnt, 1);
        checkOutput("wr_wen", sram_wen, 1);
        checkOutput("wr_ren", sram_ren, 0);
        checkOutput("wr_addr", sram_addr, 4);
        checkOutput("wr_bm", sram_bm, 32'hFFFFFFFF);
        checkOutput("wr_din", sram_din, 32'hDEADBEEF);

        // Read it straight back.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 24'h000010, 32'h0,
                            1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
        checkOutput("wr_rvalid0", p0.rvalid, 1);
        checkOutput("wr_rdata0", p0.rdata, 32'h0);
        checkOutput("rd_ren", sram_ren, 1);
        checkOutput("rd_wen", sram_wen, 0);

        // Fill word 5 with all ones, then partially overwrite it.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 24'h000014, 32'hFFFFFFFF,
                            1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
        checkOutput("rd_rdata0", p0.rdata, 32'hDEADBEEF);
        checkOutput("rd_rvalid1", p1.rvalid, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b0101, 24'h000014, 32'h11223344,
                            1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
        checkOutput("mask_bm", sram_bm, 32'h00FF00FF);
        checkOutput("mask_addr", sram_addr, 5);

        // be=0000 is still granted but leaves memory untouched.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b0000, 24'h000014, 32'h0,
                            1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
        checkOutput("be0_gnt0", p0.gnt, 1);
        checkOutput("be0_men", sram_men, 1);
        checkOutput("be0_bm", sram_bm, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 24'h000014, 32'h0,
                            1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
        checkOutput("be0_rvalid0", p0.rvalid, 1);

        // Idle cycle: read data arrives, SRAM pins go quiet.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0,
                            1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
        checkOutput("mask_rdata0", p0.rdata, 32'hFF22FF44);
        checkOutput("idle_men", sram_men, 0);
        checkOutput("idle_gnt0", p0.gnt, 0);
        checkOutput("idle_addr", sram_addr, 0);
        checkOutput("idle_din", sram_din, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0,
                            1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
        checkOutput("idle_rvalid0", p0.rvalid, 0);
        checkOutput("idle_rdata0", p0.rdata, 0);

        // Port 1 alone writes A5A5A5A5 to word 16; this leaves last=1.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0,
                            1'b1, 1'b1, 4'hF, 24'h000040, 32'hA5A5A5A5);
        checkOutput("p1_gnt1", p1.gnt, 1);
        checkOutput("p1_addr", sram_addr, 16);

        // Contention: both read for 6 cycles, grants alternate 0,1,0,1,0,1.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 24'h000014, 32'h0,
                                1'b1, 1'b0, 4'hF, 24'h000040, 32'h0);
            checkOutput($sformatf("rr_gnt0_%0d", i), p0.gnt, (i % 2 == 0) ? 1 : 0);
            checkOutput($sformatf("rr_gnt1_%0d", i), p1.gnt, (i % 2 == 0) ? 0 : 1);
            checkOutput($sformatf("rr_rvalid0_%0d", i), p0.rvalid, (i % 2 == 1) ? 1 : 0);
            checkOutput($sformatf("rr_rvalid1_%0d", i), p1.rvalid, (i % 2 == 0) ? 1 : 0);
            checkOutput($sformatf("rr_rdata0_%0d", i), p0.rdata,
                        (i % 2 == 1) ? 32'hFF22FF44 : 32'h0);
            checkOutput($sformatf("rr_rdata1_%0d", i), p1.rdata,
                        (i == 0 || i % 2 == 1) ? 32'h0 : 32'hA5A5A5A5);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0,
                            1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
        checkOutput("rr_tail_rvalid1", p1.rvalid, 1);
        checkOutput("rr_tail_rdata1", p1.rdata, 32'hA5A5A5A5);
        checkOutput("rr_tail_rvalid0", p0.rvalid, 0);

        // Address wrap: byte 0x1000 maps to word 0; reset right after the grant.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 24'h001000, 32'h12345678,
                            1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
        checkOutput("wrap_gnt0", p0.gnt, 1);
        checkOutput("wrap_addr", sram_addr, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0,
                            1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
        checkOutput("wrap_rst_rvalid0", p0.rvalid, 0);
        checkOutput("wrap_rst_rdata0", p0.rdata, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 24'h0, 32'h0,
                            1'b0, 1'b0, 4'h0, 24'h0, 32'h0);
        checkOutput("wrap_post_rvalid0", p0.rvalid, 0);

        // Fixed priority: port 0 keeps winning until it drops its request.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            f0.req = 1'b1; f0.we = 1'b0; f0.be = 4'hF; f0.addr = 24'h000008;
            f1.req = 1'b1; f1.we = 1'b0; f1.be = 4'hF; f1.addr = 24'h00000C;
            #1;
            checkOutput($sformatf("fx_gnt0_%0d", i), f0.gnt, 1);
            checkOutput($sformatf("fx_gnt1_%0d", i), f1.gnt, 0);
            checkOutput($sformatf("fx_addr_%0d", i), fx_addr, 2);
        end
        @(negedge clk);
        f0.req = 1'b0;
        #1;
        checkOutput("fx_drop_gnt1", f1.gnt, 1);
        checkOutput("fx_drop_addr", fx_addr, 3);
        checkOutput("fx_drop_rvalid0", f0.rvalid, 1);
        @(negedge clk);
        f1.req = 1'b0;
        #1;
        checkOutput("fx_end_rvalid1", f1.rvalid, 1);
        checkOutput("fx_end_men", fx_men, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
